text_console_ctrl: RTL

Sequencer for the 70×30 character video RAM that the VGA text displayer reads. It accepts ASCII codes from the keyboard path over a valid/ready handshake and turns them into RAM writes. It maintains the cursor position and implements wrap, enter, backspace, arrow movement and hardware scrolling. Scrolling uses a row-offset register that the displayer adds to its row address; the controller clears only the newly exposed row.

---
 rtl/console_pkg.sv | 40 ++++
 rtl/console_row_map.sv | 18 +
 rtl/text_console_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared state encoding and key codes for the text console controller.
// Build option CONSOLE_PROMPT_EN adds the prompt state and moves the line start to column 2.
package console_pkg;

  localparam int DEF_COLS = 70;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] BLANK_CODE  = 8'h00;
  localparam logic [7:0] PROMPT_CODE = 8'h3E;

  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_UP    = 8'h11;
  localparam logic [7:0] KEY_DOWN  = 8'h12;
  localparam logic [7:0] KEY_LEFT  = 8'h13;
  localparam logic [7:0] KEY_RIGHT = 8'h14;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

`ifdef CONSOLE_PROMPT_EN
  localparam logic [6:0] LINE_START = 7'd2;
`else
  localparam logic [6:0] LINE_START = 7'd0;
`endif

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
`ifdef CONSOLE_PROMPT_EN
    ST_PROMPT,
`endif
    ST_CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= PRINT_LO) && (code <= PRINT_HI);
  endfunction

endpackage

// File: rtl/console_row_map.sv
// Logical-to-physical row mapping for the scrolled video RAM; shared with the display read path.
module console_row_map
  import console_pkg::*;
#(
  parameter int ROWS = DEF_ROWS
) (
  input  logic [4:0] row,
  input  logic [4:0] base,
  output logic [4:0] phys
);

  logic [5:0] sum;

  // A single conditional subtract suffices because both operands are below ROWS.
  assign sum  = {1'b0, row} + {1'b0, base};
  assign phys = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];

endmodule

// File: rtl/text_console_ctrl.sv
// Turns keyboard codes into video RAM writes, tracking the cursor and hardware scroll offset.
// Build option CONSOLE_PROMPT_EN writes a prompt after init and after every enter.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_ascii,
  output logic       in_ready,
  output logic       vwr_en,
  output logic [6:0] vwraddr_h,
  output logic [4:0] vwraddr_v,
  output logic [7:0] vwrdata,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic [4:0] scroll_base
);

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [6:0] COL_END = 7'(COLS);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
  localparam logic [4:0] ROW_END = 5'(ROWS);

  state_t     state, state_n;
  logic [6:0] x_n, cnt, cnt_n, h_n;
  logic [4:0] y_n, base_n, row_cnt, row_cnt_n, v_n;
  logic [4:0] map_row, map_phys;
  logic [7:0] d_n;
  logic       wr_n, scroll_pend, scroll_n;
`ifdef CONSOLE_PROMPT_EN
  logic       prompt_pend, prompt_n;
`endif

  assign in_ready = (state == ST_IDLE);

  // Backspace from column 0 targets the previous row; everything else uses the cursor row.
  assign map_row = (state == ST_IDLE && in_ascii == KEY_BKSP && cur_x == 7'd0)
                   ? cur_y - 5'd1 : cur_y;

  console_row_map #(.ROWS(ROWS)) u_row_map (
    .row  (map_row),
    .base (scroll_base),
    .phys (map_phys)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n   = state;
    x_n       = cur_x;
    y_n       = cur_y;
    base_n    = scroll_base;
    cnt_n     = cnt;
    row_cnt_n = row_cnt;
    scroll_n  = scroll_pend;
    wr_n      = 1'b0;
    h_n       = vwraddr_h;
    v_n       = vwraddr_v;
    d_n       = vwrdata;
`ifdef CONSOLE_PROMPT_EN
    prompt_n  = prompt_pend;
`endif
    case (state)
      ST_INIT: begin
        if (row_cnt < ROW_END) begin
          wr_n = 1'b1;
          h_n  = cnt;
          v_n  = row_cnt;
          d_n  = BLANK_CODE;
          if (cnt == COL_MAX) begin
            cnt_n     = 7'd0;
            row_cnt_n = row_cnt + 5'd1;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end else begin
          cnt_n     = 7'd0;
          row_cnt_n = 5'd0;
          x_n       = LINE_START;
`ifdef CONSOLE_PROMPT_EN
          wr_n    = 1'b1;
          h_n     = 7'd0;
          v_n     = map_phys;
          d_n     = PROMPT_CODE;
          state_n = ST_PROMPT;
`else
          state_n = ST_IDLE;
`endif
        end
      end

      ST_IDLE: begin
        if (in_valid) begin
          state_n = ST_WRITE;
          if (is_printable(in_ascii)) begin
            wr_n = 1'b1;
            h_n  = cur_x;
            v_n  = map_phys;
            d_n  = in_ascii;
            if (cur_x < COL_MAX) begin
              x_n = cur_x + 7'd1;
            end else begin
              x_n = 7'd0;
              if (cur_y < ROW_MAX) y_n = cur_y + 5'd1;
              else                 scroll_n = 1'b1;
            end
          end else begin
            case (in_ascii)
              KEY_ENTER: begin
                x_n = LINE_START;
                if (cur_y < ROW_MAX) y_n = cur_y + 5'd1;
                else                 scroll_n = 1'b1;
`ifdef CONSOLE_PROMPT_EN
                prompt_n = 1'b1;
`endif
              end
              KEY_BKSP: begin
                if (cur_x != 7'd0) begin
                  x_n  = cur_x - 7'd1;
                  wr_n = 1'b1;
                  h_n  = cur_x - 7'd1;
                  v_n  = map_phys;
                  d_n  = BLANK_CODE;
                end else if (cur_y != 5'd0) begin
                  x_n  = COL_MAX;
                  y_n  = cur_y - 5'd1;
                  wr_n = 1'b1;
                  h_n  = COL_MAX;
                  v_n  = map_phys;
                  d_n  = BLANK_CODE;
                end
              end
              KEY_UP:    if (cur_y != 5'd0)   y_n = cur_y - 5'd1;
              KEY_DOWN:  if (cur_y < ROW_MAX) y_n = cur_y + 5'd1;
              KEY_LEFT:  if (cur_x != 7'd0)   x_n = cur_x - 7'd1;
              KEY_RIGHT: if (cur_x < COL_MAX) x_n = cur_x + 7'd1;
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        // The bottom row after the scroll is the physical row that used to be on top.
        if (scroll_pend) begin
          scroll_n  = 1'b0;
          base_n    = (scroll_base == ROW_MAX) ? 5'd0 : scroll_base + 5'd1;
          row_cnt_n = scroll_base;
          cnt_n     = 7'd1;
          wr_n      = 1'b1;
          h_n       = 7'd0;
          v_n       = scroll_base;
          d_n       = BLANK_CODE;
          state_n   = ST_CLEAR;
        end
`ifdef CONSOLE_PROMPT_EN
        else if (prompt_pend) begin
          prompt_n = 1'b0;
          wr_n     = 1'b1;
          h_n      = 7'd0;
          v_n      = map_phys;
          d_n      = PROMPT_CODE;
          state_n  = ST_PROMPT;
        end
`endif
        else begin
          state_n = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (cnt < COL_END) begin
          wr_n  = 1'b1;
          h_n   = cnt;
          v_n   = row_cnt;
          d_n   = BLANK_CODE;
          cnt_n = cnt + 7'd1;
        end else begin
          cnt_n = 7'd0;
`ifdef CONSOLE_PROMPT_EN
          if (prompt_pend) begin
            prompt_n = 1'b0;
            wr_n     = 1'b1;
            h_n      = 7'd0;
            v_n      = map_phys;
            d_n      = PROMPT_CODE;
            state_n  = ST_PROMPT;
          end else begin
            state_n = ST_IDLE;
          end
`else
          state_n = ST_IDLE;
`endif
        end
      end

`ifdef CONSOLE_PROMPT_EN
      ST_PROMPT: state_n = ST_IDLE;
`endif

      default: state_n = ST_INIT;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      cur_x       <= 7'd0;
      cur_y       <= 5'd0;
      scroll_base <= 5'd0;
      cnt         <= 7'd0;
      row_cnt     <= 5'd0;
      scroll_pend <= 1'b0;
      vwr_en      <= 1'b0;
      vwraddr_h   <= 7'd0;
      vwraddr_v   <= 5'd0;
      vwrdata     <= 8'h00;
`ifdef CONSOLE_PROMPT_EN
      prompt_pend <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cur_x       <= x_n;
      cur_y       <= y_n;
      scroll_base <= base_n;
      cnt         <= cnt_n;
      row_cnt     <= row_cnt_n;
      scroll_pend <= scroll_n;
      vwr_en      <= wr_n;
      vwraddr_h   <= h_n;
      vwraddr_v   <= v_n;
      vwrdata     <= d_n;
`ifdef CONSOLE_PROMPT_EN
      prompt_pend <= prompt_n;
`endif
    end
  end

endmodule
